// File: rtl/vga_sync_gen_if.sv
// Timing bundle from vga_sync_gen to the shape generators and RGB mux.
// VGA_FRAME_COUNT_EN adds the frame_count member.
interface vga_sync_gen_if;
    logic       pixel_tick;
    logic [9:0] HCount;
    logic [9:0] VCount;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic       frame_start;
    logic       line_start;
`ifdef VGA_FRAME_COUNT_EN
    logic [7:0] frame_count;

    modport master (
        output pixel_tick, HCount, VCount, hsync, vsync, video_on,
               frame_start, line_start, frame_count
    );

    modport slave (
        input pixel_tick, HCount, VCount, hsync, vsync, video_on,
              frame_start, line_start, frame_count
    );
`else
    modport master (
        output pixel_tick, HCount, VCount, hsync, vsync, video_on,
               frame_start, line_start
    );

    modport slave (
        input pixel_tick, HCount, VCount, hsync, vsync, video_on,
              frame_start, line_start
    );
`endif
endinterface

// File: rtl/vga_sync_gen.sv
// 640x480@60 VGA timing generator: pixel-enable divider, raster counters, sync decodes.
// Optional VGA_FRAME_COUNT_EN adds an 8-bit wrapping frame counter.
module vga_sync_gen #(
    parameter int unsigned CLK_DIV   = 2,
    parameter int unsigned H_DISPLAY = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_DISPLAY = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33
) (
    input  logic           clk,
    input  logic           reset,
    vga_sync_gen_if.master vga
);
    localparam int unsigned CNT_W   = 10;
    localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST     = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] H_LAST       = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST       = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS        = CNT_W'(H_DISPLAY);
    localparam logic [CNT_W-1:0] V_VIS        = CNT_W'(V_DISPLAY);
    localparam logic [CNT_W-1:0] H_SYNC_START = CNT_W'(H_DISPLAY + H_FRONT);
    localparam logic [CNT_W-1:0] H_SYNC_END   = CNT_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [CNT_W-1:0] V_SYNC_START = CNT_W'(V_DISPLAY + V_FRONT);
    localparam logic [CNT_W-1:0] V_SYNC_END   = CNT_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] h_q, h_d;
    logic [CNT_W-1:0] v_q, v_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             video_q, video_d;
    logic             tick_c;
    logic             line_end_c;
    logic             frame_end_c;

    // Tick is masked during reset so CLK_DIV=1 still reads 0 while held in reset.
    assign tick_c      = (div_q == DIV_LAST) && !reset;
    assign line_end_c  = tick_c && (h_q == H_LAST);
    assign frame_end_c = line_end_c && (v_q == V_LAST);

    // Next-state: divider wrap, raster advance, and decodes of the next position.
    always_comb begin
        div_d = div_q;
        h_d   = h_q;
        v_d   = v_q;

        if (div_q == DIV_LAST) begin
            div_d = '0;
        end else begin
            div_d = div_q + DIV_W'(1);
        end

        if (tick_c) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                if (v_q == V_LAST) begin
                    v_d = '0;
                end else begin
                    v_d = v_q + CNT_W'(1);
                end
            end else begin
                h_d = h_q + CNT_W'(1);
            end
        end

        hsync_d = !((h_d >= H_SYNC_START) && (h_d <= H_SYNC_END));
        vsync_d = !((v_d >= V_SYNC_START) && (v_d <= V_SYNC_END));
        video_d = (h_d < H_VIS) && (v_d < V_VIS);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q   <= '0;
            h_q     <= '0;
            v_q     <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            video_q <= 1'b1;
        end else begin
            div_q   <= div_d;
            h_q     <= h_d;
            v_q     <= v_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            video_q <= video_d;
        end
    end

    assign vga.pixel_tick  = tick_c;
    assign vga.HCount      = h_q;
    assign vga.VCount      = v_q;
    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.video_on    = video_q;
    assign vga.line_start  = line_end_c;
    assign vga.frame_start = frame_end_c;

`ifdef VGA_FRAME_COUNT_EN
    logic [7:0] frame_cnt_q;

    // Free-running frame index for blink/animation; wraps naturally at 8 bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt_q <= '0;
        end else if (frame_end_c) begin
            frame_cnt_q <= frame_cnt_q + 8'(1);
        end
    end

    assign vga.frame_count = frame_cnt_q;
`endif
endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Generates 640x480@60 Hz VGA timing: HCount/VCount pixel coordinates, active-low hsync/vsync, video_on and per-frame markers.
- Sits directly upstream of the shape pixel generators (triangle/square/circle objects) and the RGB mux.
- Its HCount/VCount feed those objects' bounding-box and ROM address arithmetic.
- Divides the 50 MHz board clock to a 25 MHz pixel-enable tick; all logic runs on one clock.

Parameters:
CLK_DIV, 2, system clocks per pixel (pixel_tick period); legal values ≥1
H_DISPLAY, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_DISPLAY, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BACK, 33, vertical back porch (lines)

Ports:
clk  input  1  system clock, 50 MHz
reset  input  1  asynchronous, active-high reset
pixel_tick  output  1  one-clk pulse every CLK_DIV clocks; counters advance on it
HCount  output  10  current column, 0..H_TOTAL-1
VCount  output  10  current line, 0..V_TOTAL-1
hsync  output  1  horizontal sync, active low, registered
vsync  output  1  vertical sync, active low, registered
video_on  output  1  high when HCount<H_DISPLAY and VCount<V_DISPLAY, registered
frame_start  output  1  one-clk pulse on the last pixel_tick of a frame
line_start  output  1  one-clk pulse on the last pixel_tick of each line

Behaviour:
- Interface fact: single clock clk; reset is asynchronous, active-high.
- Derived totals: H_TOTAL = sum of the H_* parameters (800 by default); V_TOTAL = sum of the V_* parameters (525 by default).
- Reset values: div counter 0, HCount 0, VCount 0, hsync 1, vsync 1, video_on 1 (position 0,0 is visible), pixel_tick 0, frame_start 0, line_start 0.
- Reset is honoured mid-frame: all state returns to the reset values immediately. No partial sync pulse is held.
- Divider:
  - Counts 0..CLK_DIV-1 and wraps to 0.
  - pixel_tick = 1 while div == CLK_DIV-1 (combinational decode of the registered counter).
  - With CLK_DIV=1, pixel_tick is constantly 1 after reset.
- Counter update, on a clk edge with pixel_tick=1:
  - If HCount == H_TOTAL-1, HCount goes to 0; otherwise HCount increments by 1.
  - On the HCount wrap: if VCount == V_TOTAL-1, VCount goes to 0; otherwise VCount increments by 1.
  - Without pixel_tick, all counters hold.
- Registered decodes (hsync, vsync, video_on) are computed from the next counter values. They change in the same edge as HCount/VCount and always match the current counts (zero-latency alignment).
  - hsync = 0 iff H_DISPLAY+H_FRONT ≤ HCount ≤ H_DISPLAY+H_FRONT+H_SYNC-1 (656..751 by default).
  - vsync = 0 iff V_DISPLAY+V_FRONT ≤ VCount ≤ V_DISPLAY+V_FRONT+V_SYNC-1 (490..491 by default).
- line_start (combinational) = pixel_tick & (HCount == H_TOTAL-1).
- frame_start (combinational) = line_start & (VCount == V_TOTAL-1).
  - Both pulse for exactly one clk, the cycle before the counts advance to column 0 / position (0,0).
- Width rule: counters are 10 bits; H_TOTAL and V_TOTAL must be ≤1024. Compare against constants of matching width, with no truncation.

Optional Feature:
- Macro: VGA_FRAME_COUNT_EN.
- When defined:
  - Adds output frame_count [7:0], reset 0.
  - Increments by 1 on each clk where frame_start=1, and wraps 255→0.
  - Used by downstream objects for blink/animation.
- When undefined: the port and its register do not exist; all other behaviour is identical.

Test Plan:
- Reset released, CLK_DIV=2 → pixel_tick high every 2nd clk; HCount steps 0,1,2… once per tick; video_on=1, hsync=vsync=1 at (0,0).
- Run one full line → hsync low for exactly 96 ticks, starting at HCount=656 and ending after 751. line_start pulses once at HCount=799 with pixel_tick; the next tick gives HCount=0, VCount=1.
- Run one full frame → vsync low only on VCount 490–491 (1600 ticks). video_on is high for exactly 307200 ticks. frame_start pulses once at (799,524); the next state is (0,0).
- Assert reset at HCount=700, VCount=491 (hsync and vsync both low), asynchronously between edges → all outputs return to reset values immediately, without waiting for a clk edge; the counting sequence restarts from (0,0) after release.
- CLK_DIV=1 → pixel_tick constantly 1; a frame lasts exactly 420000 clks between frame_start pulses.
- With VGA_FRAME_COUNT_EN, 257 frames → frame_count reads 1 (wrapped 255→0→1). Without the macro, the same bench compiles without the port.
